// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined carry-lookahead adder.
package pipelined_cla_adder_pkg;

    // Bits per first-level lookahead group.
    localparam int GROUP_W = 4;

    // Groups per second-level lookahead cluster; cluster carries are chained.
    localparam int CLUSTER = 4;

    // Operand width used when a parent does not override it.
    localparam int DEFAULT_WIDTH = 16;

    // Ceiling log2, handy for sizing indices over the group count.
    function automatic int clog(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // Number of clusters needed to cover ngroup lookahead groups.
    function automatic int ncluster(input int ngroup);
        return (ngroup + CLUSTER - 1) / CLUSTER;
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for the pipelined carry-lookahead adder.
interface pipelined_cla_adder_if
    import pipelined_cla_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    // Operand side
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;

    // Result side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Operand source and result consumer.
    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    // The adder itself.
    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/pipelined_cla_adder_cla_group4.sv
// Combinational 4-bit carry-lookahead group: intra-group carries plus group propagate/generate.
module cla_group4
    import pipelined_cla_adder_pkg::*;
(
    input  logic [GROUP_W-1:0] p,
    input  logic [GROUP_W-1:0] g,
    input  logic               ci,
    output logic [3:1]         c,
    output logic               pg,
    output logic               gg
);

    // Carries into bits 1..3 from the group carry-in, flattened sum-of-products.
    assign c[1] = g[0]
                | (p[0] & ci);
    assign c[2] = g[1]
                | (p[1] & g[0])
                | (p[1] & p[0] & ci);
    assign c[3] = g[2]
                | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);

    // Group terms consumed by the second-level lookahead network.
    assign pg = &p;
    assign gg = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/pipelined_cla_adder.sv
// Three-stage carry-lookahead adder/subtractor with valid/ready flow control.
// S1 registers the conditioned operands, S2 the per-bit p/g plus all group
// carries, S3 the final sum, carry-out and signed overflow.
module pipelined_cla_adder
    import pipelined_cla_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic                 clk,
    input logic                 rst,
    pipelined_cla_adder_if.slave bus
);

    localparam int NGROUP = WIDTH / GROUP_W;
    localparam int NCLUST = ncluster(NGROUP);
    localparam int NPAD   = NCLUST * CLUSTER;

    // Handshake and stage occupancy
    logic adv;
    logic s1_valid;
    logic s2_valid;
    logic s3_valid;

    // S1 state and its combinational per-bit terms
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_bb;
    logic             s1_c0;
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;

    // Group terms and second-level carry network (padded to whole clusters)
    logic [NGROUP-1:0]   grp_pg;
    logic [NGROUP-1:0]   grp_gg;
    logic [NPAD-1:0]     pad_pg;
    logic [NPAD-1:0]     pad_gg;
    logic [NPAD:0]       net_carry;
    logic [3*NGROUP-1:0] s2_unused_c;
    logic                s2_unused_net;

    // S2 state
    logic [WIDTH-1:0] s2_p;
    logic [WIDTH-1:0] s2_g;
    logic [NGROUP:0]  s2_carry;

    // S3 combinational carries and registered outputs
    logic [WIDTH-1:0]  bit_carry;
    logic [WIDTH-1:0]  sum_d;
    logic [NGROUP-1:0] s3_unused_pg;
    logic [NGROUP-1:0] s3_unused_gg;
    logic [WIDTH-1:0]  s3_sum;
    logic              s3_cout;
    logic              s3_ovf;

    // The whole pipe moves as one unit unless a held result is blocking it.
    assign adv          = !s3_valid || bus.out_ready;
    assign bus.in_ready = adv;

    // Stage valid bits: shift together on adv, bubbles are kept in place.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every stage samples its neighbour's pre-edge value.
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= bus.in_valid;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
        end
    end

    // S1: capture A, B conditioned for subtract, and the effective carry-in.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers carry no reset; the valid bits alone decide whether their contents are meaningful.
        if (adv) begin
            s1_a  <= bus.a;
            s1_bb <= bus.b ^ {WIDTH{bus.sub}};
            s1_c0 <= bus.sub | bus.cin;
        end
    end

    assign s1_p = s1_a ^ s1_bb;
    assign s1_g = s1_a & s1_bb;

    // S2 groups: only PG/GG are used here, the intra-group carries come later in S3.
    for (genvar k = 0; k < NGROUP; k++) begin : g_s2_grp
        cla_group4 u_grp (
            .p  (s1_p[GROUP_W*k +: GROUP_W]),
            .g  (s1_g[GROUP_W*k +: GROUP_W]),
            .ci (1'b0),
            .c  (s2_unused_c[3*k +: 3]),
            .pg (grp_pg[k]),
            .gg (grp_gg[k])
        );
    end

    // Missing groups in the last cluster neither propagate nor generate.
    assign pad_pg = NPAD'(grp_pg);
    assign pad_gg = NPAD'(grp_gg);

    // Second-level lookahead: flattened sum-of-products inside a cluster, cluster carries chained.
    always_comb begin
        logic acc;
        logic prod;
        // NOTE: every always_comb output and temporary gets a default first so no path can infer a latch.
        acc          = 1'b0;
        prod         = 1'b0;
        net_carry    = '0;
        net_carry[0] = s1_c0;
        for (int j = 0; j < NCLUST; j++) begin
            for (int m = 0; m < CLUSTER; m++) begin
                acc = 1'b0;
                for (int t = 0; t <= m; t++) begin
                    prod = pad_gg[j*CLUSTER + t];
                    for (int u = t + 1; u <= m; u++) begin
                        prod = prod & pad_pg[j*CLUSTER + u];
                    end
                    acc = acc | prod;
                end
                prod = net_carry[j*CLUSTER];
                for (int u = 0; u <= m; u++) begin
                    prod = prod & pad_pg[j*CLUSTER + u];
                end
                net_carry[j*CLUSTER + m + 1] = acc | prod;
            end
        end
    end

    // Carries of padding groups are never consumed.
    assign s2_unused_net = ^net_carry;

    // S2: register per-bit terms and every group boundary carry.
    always_ff @(posedge clk) begin
        if (adv) begin
            s2_p     <= s1_p;
            s2_g     <= s1_g;
            s2_carry <= net_carry[NGROUP:0];
        end
    end

    // S3 groups: expand each group carry-in into the three intra-group carries.
    for (genvar k = 0; k < NGROUP; k++) begin : g_s3_grp
        assign bit_carry[GROUP_W*k] = s2_carry[k];
        cla_group4 u_grp (
            .p  (s2_p[GROUP_W*k +: GROUP_W]),
            .g  (s2_g[GROUP_W*k +: GROUP_W]),
            .ci (s2_carry[k]),
            .c  (bit_carry[GROUP_W*k + 1 +: 3]),
            .pg (s3_unused_pg[k]),
            .gg (s3_unused_gg[k])
        );
    end

    assign sum_d = s2_p ^ bit_carry;

    // S3: results update only for real beats, so bubbles leave the last result in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_sum  <= '0;
            s3_cout <= 1'b0;
            s3_ovf  <= 1'b0;
        end else if (adv && s2_valid) begin
            s3_sum  <= sum_d;
            s3_cout <= s2_carry[NGROUP];
            s3_ovf  <= bit_carry[WIDTH-1] ^ s2_carry[NGROUP];
        end
    end

    assign bus.out_valid = s3_valid;
    assign bus.sum       = s3_sum;
    assign bus.cout      = s3_cout;
    assign bus.ovf       = s3_ovf;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder at WIDTH = 4, 16 and 64 driven in lockstep.
module tb_pipelined_cla_adder;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        cin;
        logic [15:0] s;
        logic        co;
        logic        of;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        drv_valid = 1'b0;
    logic        drv_ready = 1'b1;
    logic        drv_sub = 1'b0;
    logic        drv_cin = 1'b0;
    logic [63:0] drv_a = '0;
    logic [63:0] drv_b = '0;

    int   total = 0;
    int   bad = 0;
    exp_t q4[$];
    exp_t q16[$];
    exp_t q64[$];

    logic        stall16 = 1'b0;
    logic [18:0] hold16 = '0;

    always #5 clk = ~clk;

    pipelined_cla_adder_if #(.WIDTH(4))  if4 ();
    pipelined_cla_adder_if #(.WIDTH(16)) if16 ();
    pipelined_cla_adder_if #(.WIDTH(64)) if64 ();

    assign if4.in_valid   = drv_valid;
    assign if4.out_ready  = drv_ready;
    assign if4.sub        = drv_sub;
    assign if4.cin        = drv_cin;
    assign if4.a          = drv_a[3:0];
    assign if4.b          = drv_b[3:0];
    assign if16.in_valid  = drv_valid;
    assign if16.out_ready = drv_ready;
    assign if16.sub       = drv_sub;
    assign if16.cin       = drv_cin;
    assign if16.a         = drv_a[15:0];
    assign if16.b         = drv_b[15:0];
    assign if64.in_valid  = drv_valid;
    assign if64.out_ready = drv_ready;
    assign if64.sub       = drv_sub;
    assign if64.cin       = drv_cin;
    assign if64.a         = drv_a;
    assign if64.b         = drv_b;

    pipelined_cla_adder #(.WIDTH(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if4));
    pipelined_cla_adder #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));
    pipelined_cla_adder #(.WIDTH(64)) u_dut64 (.clk(clk), .rst(rst), .bus(if64));

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: unsigned and signed integer arithmetic on w-bit operands.
    function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic sub, input logic cin);
        exp_t               e;
        logic [63:0]        mask;
        logic [63:0]        ua;
        logic [63:0]        ub;
        logic [65:0]        t;
        logic signed [67:0] one;
        logic signed [67:0] sa;
        logic signed [67:0] sb;
        logic signed [67:0] sr;
        logic signed [67:0] lim;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        ua   = a & mask;
        ub   = b & mask;
        if (!sub) begin
            t      = {2'b00, ua} + {2'b00, ub} + {65'd0, cin};
            e.cout = t[w];
        end else begin
            t      = {2'b00, ua} - {2'b00, ub};
            e.cout = (ua >= ub);
        end
        e.sum = t[63:0] & mask;
        one   = 68'sd1;
        sa    = $signed({4'b0000, ua});
        sb    = $signed({4'b0000, ub});
        if (ua[w-1]) sa = sa - (one <<< w);
        if (ub[w-1]) sb = sb - (one <<< w);
        sr    = sub ? (sa - sb) : (sa + sb + $signed({67'd0, cin}));
        lim   = one <<< (w - 1);
        e.ovf = (sr >= lim) || (sr < -lim);
        return e;
    endfunction

    task automatic push_all(input bit use_fixed, input exp_t fixed16);
        q4.push_back(model(4, drv_a, drv_b, drv_sub, drv_cin));
        q16.push_back(use_fixed ? fixed16 : model(16, drv_a, drv_b, drv_sub, drv_cin));
        q64.push_back(model(64, drv_a, drv_b, drv_sub, drv_cin));
    endtask

    task automatic mon_one(input int w, input logic ov, input logic rd, input logic [63:0] s,
                           input logic co, input logic of);
        exp_t e;
        int   sz;
        if (ov && rd) begin
            sz = (w == 4) ? q4.size() : (w == 16) ? q16.size() : q64.size();
            if (sz == 0) begin
                check($sformatf("spurious_out_w%0d", w), 68'(ov), 68'd0);
            end else begin
                if (w == 4)       e = q4.pop_front();
                else if (w == 16) e = q16.pop_front();
                else              e = q64.pop_front();
                check($sformatf("result_w%0d", w), {2'b00, s, co, of}, {2'b00, e});
            end
        end
    endtask

    // Monitor: sample mid-cycle, pop and compare on every output transfer.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            stall16 = 1'b0;
        end else begin
            if (stall16) begin
                check("stall_hold_w16", 68'({if16.out_valid, if16.sum, if16.cout, if16.ovf}), 68'(hold16));
            end
            mon_one(4,  if4.out_valid,  if4.out_ready,  64'(if4.sum),  if4.cout,  if4.ovf);
            mon_one(16, if16.out_valid, if16.out_ready, 64'(if16.sum), if16.cout, if16.ovf);
            mon_one(64, if64.out_valid, if64.out_ready, if64.sum,      if64.cout, if64.ovf);
            stall16 = if16.out_valid && !if16.out_ready;
            hold16  = {if16.out_valid, if16.sum, if16.cout, if16.ovf};
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_out_w4"},  68'({if4.out_valid,  if4.sum,  if4.cout,  if4.ovf}),  68'd0);
        check({tag, "_out_w16"}, 68'({if16.out_valid, if16.sum, if16.cout, if16.ovf}), 68'd0);
        check({tag, "_out_w64"}, 68'({if64.out_valid, if64.sum, if64.cout, if64.ovf}), 68'd0);
        check({tag, "_in_ready"}, 68'(if16.in_ready), 68'd1);
    endtask

    task automatic single_beat(input vec_t v, input int idx);
        exp_t e;
        int   cnt;
        @(negedge clk);
        drv_valid = 1'b1;
        drv_ready = 1'b1;
        drv_a     = 64'(v.a);
        drv_b     = 64'(v.b);
        drv_sub   = v.sub;
        drv_cin   = v.cin;
        #1;
        check($sformatf("dir%0d_accept", idx), 68'(if16.in_ready), 68'd1);
        if (if16.in_ready) begin
            e.sum  = 64'(v.s);
            e.cout = v.co;
            e.ovf  = v.of;
            push_all(1'b1, e);
        end
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
        cnt = 1;
        while (!if16.out_valid && cnt < 10) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check($sformatf("dir%0d_latency", idx), 68'(cnt), 68'd3);
        @(posedge clk);
        #1;
        check($sformatf("dir%0d_pulse", idx), 68'(if16.out_valid), 68'd0);
    endtask

    task automatic wait_drain(input string name);
        int cnt;
        cnt = 0;
        while ((q4.size() + q16.size() + q64.size()) != 0 && cnt < 50) begin
            @(negedge clk);
            drv_valid = 1'b0;
            drv_ready = 1'b1;
            cnt++;
        end
        check(name, 68'(q4.size() + q16.size() + q64.size()), 68'd0);
    endtask

    // Safety net in case the stimulus itself stalls forever.
    initial begin
        #2000000;
        $display("FAIL watchdog: stimulus did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        exp_t e;
        int   sent;
        int   accepted;
        int   cyc;

        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};

        // Reset state
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // Directed vectors with latency and single-cycle pulse checks
        for (int i = 0; i < 5; i++) begin
            single_beat(vecs[i], i);
        end
        wait_drain("dir_drain");

        // Backpressure: five beats, consumer stalls in cycles 4..8
        sent = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            drv_ready = !(c >= 4 && c <= 8);
            drv_valid = (sent < 5);
            drv_a     = 64'(sent);
            drv_b     = 64'(sent);
            drv_sub   = 1'b0;
            drv_cin   = 1'b0;
            #1;
            if (c <= 9) begin
                check($sformatf("bp_in_ready_c%0d", c), 68'(if16.in_ready), 68'((c < 4) || (c == 9)));
            end
            if (drv_valid && if16.in_ready) begin
                e.sum  = 64'(2 * sent);
                e.cout = 1'b0;
                e.ovf  = 1'b0;
                push_all(1'b1, e);
                sent++;
            end
        end
        check("bp_sent", 68'(sent), 68'd5);
        wait_drain("bp_drain");

        // Mid-operation reset with three beats in flight
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drv_valid = 1'b1;
            drv_ready = 1'b1;
            drv_a     = {$urandom(), $urandom()};
            drv_b     = {$urandom(), $urandom()};
            drv_sub   = 1'($urandom_range(0, 1));
            drv_cin   = 1'($urandom_range(0, 1));
            #1;
            if (if16.in_ready) push_all(1'b0, '0);
        end
        @(negedge clk);
        drv_valid = 1'b0;
        drv_ready = 1'b0;
        rst       = 1'b1;
        q4.delete();
        q16.delete();
        q64.delete();
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("midrst");
        drv_ready = 1'b1;
        repeat (8) @(negedge clk);
        check("midrst_queues", 68'(q4.size() + q16.size() + q64.size()), 68'd0);

        // Randomized traffic with random backpressure
        accepted = 0;
        cyc      = 0;
        while (accepted < 10000 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            drv_valid = ($urandom_range(0, 3) != 0);
            drv_ready = ($urandom_range(0, 3) != 0);
            drv_a     = {$urandom(), $urandom()};
            drv_b     = {$urandom(), $urandom()};
            case ($urandom_range(0, 7))
                0:       drv_b = ~drv_a;
                1:       drv_a = '1;
                2:       drv_b = drv_a;
                default: ;
            endcase
            drv_sub = 1'($urandom_range(0, 1));
            drv_cin = 1'($urandom_range(0, 1));
            #1;
            if (drv_valid && if16.in_ready) begin
                push_all(1'b0, '0);
                accepted++;
            end
        end
        check("rand_accepted", 68'(accepted), 68'd10000);
        wait_drain("rand_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
